// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU load/store unit
// (port 0) and a loader/DMA requester (port 1). The arbiter grants at most one
// request per cycle and returns a registered response one cycle later.
// Arbitration is round-robin. A per-port lock keeps the grant on the same port,
// and a hold limit stops a locked port from starving the other one.
// Out-of-range accesses are still granted, but they never write memory.
// Instead they come back with an error strobe.

module dmem_arbiter #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned MEM_BYTES     = 32'h20000,
  parameter int          MAX_HOLD      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req0,
  input  logic                     we0,
  input  logic                     byteop0,
  input  logic                     lock0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,

  input  logic                     req1,
  input  logic                     we1,
  input  logic                     byteop1,
  input  logic                     lock1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,

  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic                     rerr0,
  output logic                     rerr1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,

  output logic                     mem_we,
  output logic                     mem_byteop,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // The hold counter only needs to reach MAX_HOLD. It saturates there.
  localparam int                     HOLD_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]      HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]      HOLD_ONE   = HOLD_W'(1);

  // The range check uses one extra bit so that addr+3 cannot wrap around.
  localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(MEM_BYTES);
  localparam logic [ADDRESS_WIDTH:0] WORD_SPAN  = (ADDRESS_WIDTH + 1)'(3);

  // Arbitration state
  port_e                  last_q, last_d;
  logic                   owner_locked_q, owner_locked_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;

  // Response registers
  logic                   rvalid0_q, rvalid0_d;
  logic                   rvalid1_q, rvalid1_d;
  logic                   rerr0_q, rerr0_d;
  logic                   rerr1_q, rerr1_d;
  logic [DATA_WIDTH-1:0]  rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]  rdata1_q, rdata1_d;

  // Combinational selection
  port_e                  winner;
  logic                   any_grant;
  logic                   contended;
  logic                   sel_we;
  logic                   sel_byteop;
  logic                   sel_lock;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [ADDRESS_WIDTH:0] sel_addr_ext;
  logic                   err;

  assign contended = req0 && req1;

  // Pick the winner. While reset is asserted, no grant is issued.
  always_comb begin
    winner    = PORT0;
    any_grant = 1'b0;
    if (rst_n) begin
      if (contended) begin
        any_grant = 1'b1;
        if (owner_locked_q && (hold_cnt_q < HOLD_LIMIT)) begin
          winner = last_q;
        end else begin
          winner = (last_q == PORT0) ? PORT1 : PORT0;
        end
      end else if (req0) begin
        any_grant = 1'b1;
        winner    = PORT0;
      end else if (req1) begin
        any_grant = 1'b1;
        winner    = PORT1;
      end
    end
  end

  assign gnt0 = any_grant && (winner == PORT0);
  assign gnt1 = any_grant && (winner == PORT1);

  // Route the winning port's request fields onto the shared bus.
  always_comb begin
    sel_we     = we0;
    sel_byteop = byteop0;
    sel_lock   = lock0;
    sel_addr   = addr0;
    sel_wdata  = wdata0;
    if (winner == PORT1) begin
      sel_we     = we1;
      sel_byteop = byteop1;
      sel_lock   = lock1;
      sel_addr   = addr1;
      sel_wdata  = wdata1;
    end
  end

  assign sel_addr_ext = {1'b0, sel_addr};

  // Flag accesses that fall outside memory, including the full span of a word access.
  always_comb begin
    err = 1'b0;
    if (sel_addr_ext >= ADDR_LIMIT) begin
      err = 1'b1;
    end else if (!sel_byteop && ((sel_addr_ext + WORD_SPAN) >= ADDR_LIMIT)) begin
      err = 1'b1;
    end
  end

  // Drive the memory port. It stays quiet when there is no grant, and a rejected access never writes.
  always_comb begin
    mem_we     = 1'b0;
    mem_byteop = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (any_grant) begin
      mem_we     = sel_we && !err;
      mem_byteop = sel_byteop;
      mem_addr   = sel_addr;
      mem_wdata  = sel_wdata;
    end
  end

  // Update the round-robin, lock and hold state on each grant. The hold count stays at 1 when there is no contention.
  always_comb begin
    last_d         = last_q;
    owner_locked_d = owner_locked_q;
    hold_cnt_d     = hold_cnt_q;
    if (any_grant) begin
      last_d         = winner;
      owner_locked_d = sel_lock;
      if (!contended) begin
        hold_cnt_d = HOLD_ONE;
      end else if (winner == last_q) begin
        hold_cnt_d = (hold_cnt_q >= HOLD_LIMIT) ? HOLD_LIMIT : hold_cnt_q + HOLD_ONE;
      end else begin
        hold_cnt_d = HOLD_ONE;
      end
    end
  end

  // Build the next response. Read data is captured only for good reads. Idle cycles keep the previous rdata.
  always_comb begin
    rvalid0_d = gnt0;
    rvalid1_d = gnt1;
    rerr0_d   = gnt0 && err;
    rerr1_d   = gnt1 && err;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (gnt0) begin
      rdata0_d = (!sel_we && !err) ? mem_rdata : '0;
    end
    if (gnt1) begin
      rdata1_d = (!sel_we && !err) ? mem_rdata : '0;
    end
  end

  // State registers. Reset discards any response that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q         <= PORT1;
      owner_locked_q <= 1'b0;
      hold_cnt_q     <= '0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      rerr0_q        <= 1'b0;
      rerr1_q        <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
    end else begin
      last_q         <= last_d;
      owner_locked_q <= owner_locked_d;
      hold_cnt_q     <= hold_cnt_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
      rerr0_q        <= rerr0_d;
      rerr1_q        <= rerr1_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rerr0   = rerr0_q;
  assign rerr1   = rerr1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter.
// The bench uses a big-endian byte-addressed memory model.
// Inputs are driven on the falling edge. Combinational outputs are checked
// 1 ns later, and registered outputs are checked 1 ns after the rising edge.

module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 32'h20000;
  localparam int MH = 8;

  logic          clk;
  logic          rst_n;
  logic          req0, we0, byteop0, lock0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1, we1, byteop1, lock1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we, mem_byteop;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [7:0]    mem [0:MB-1];
  logic [16:0]   mem_idx;

  int numChecks;
  int numFails;

  dmem_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .MEM_BYTES    (MB),
    .MAX_HOLD     (MH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .we0       (we0),
    .byteop0   (byteop0),
    .lock0     (lock0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .byteop1   (byteop1),
    .lock1     (lock1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rerr0     (rerr0),
    .rerr1     (rerr1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_we    (mem_we),
    .mem_byteop(mem_byteop),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_idx = mem_addr[16:0];

  // Memory model: combinational big-endian read; a byte read returns the byte in [7:0]
  always_comb begin
    mem_rdata = '0;
    if (mem_byteop) begin
      if (mem_addr < 32'(MB)) mem_rdata = {24'h0, mem[mem_idx]};
    end else if (mem_addr <= 32'(MB - 4)) begin
      mem_rdata = {mem[mem_idx], mem[mem_idx + 17'd1], mem[mem_idx + 17'd2], mem[mem_idx + 17'd3]};
    end
  end

  // Memory model: write on the rising edge whenever the arbiter enables it
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_byteop) begin
        mem[mem_idx] <= mem_wdata[7:0];
      end else begin
        mem[mem_idx]         <= mem_wdata[31:24];
        mem[mem_idx + 17'd1] <= mem_wdata[23:16];
        mem[mem_idx + 17'd2] <= mem_wdata[15:8];
        mem[mem_idx + 17'd3] <= mem_wdata[7:0];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, wanted %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic r0, input logic w0, input logic b0, input logic l0,
    input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic b1, input logic l1,
    input logic [31:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; byteop0 = b0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; byteop1 = b1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] memWord(input int a);
    return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
  endfunction

  initial begin
    numChecks = 0;
    numFails  = 0;
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
    mem[32'h100] = 8'hDE; mem[32'h101] = 8'hAD; mem[32'h102] = 8'hBE; mem[32'h103] = 8'hEF;

    // Reset: a write request during reset must not be granted or reach memory
    rst_n = 1'b0;
    applyStimulus(1, 1, 0, 0, 32'h100, 32'hCAFEF00D, 0, 0, 0, 0, 32'h0, 32'h0);
    #2;
    checkOutput("rst_gnt",    32'({gnt0, gnt1}), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_rvalid", 32'({rvalid0, rvalid1, rerr0, rerr1}), 32'h0);
    checkOutput("rst_rdata0", rdata0, 32'h0);
    checkOutput("rst_rdata1", rdata1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_no_write", memWord(32'h100), 32'hDEADBEEF);
    applyIdle();
    rst_n = 1'b1;

    // Basic read of 0x100 on port 0
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 32'h100, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("rd_gnt",      32'({gnt0, gnt1}), 32'h2);
    checkOutput("rd_mem_addr", mem_addr, 32'h100);
    checkOutput("rd_mem_we",   32'(mem_we), 32'h0);
    @(posedge clk); #1;
    checkOutput("rd_rvalid", 32'({rvalid0, rvalid1}), 32'h2);
    checkOutput("rd_rdata0", rdata0, 32'hDEADBEEF);
    checkOutput("rd_rerr0",  32'(rerr0), 32'h0);

    // Alternation: last is port 0, so port 1 goes first
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 32'h10, 32'h0, 1, 0, 0, 0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("alt_gnt_%0d", i), 32'({gnt0, gnt1}), (i % 2 == 0) ? 32'h1 : 32'h2);
      checkOutput($sformatf("alt_addr_%0d", i), mem_addr, (i % 2 == 0) ? 32'h20 : 32'h10);
      @(posedge clk); #1;
      checkOutput($sformatf("alt_rvalid_%0d", i), 32'({rvalid0, rvalid1}), (i % 2 == 0) ? 32'h1 : 32'h2);
      @(negedge clk);
    end

    // A solo port 1 read leaves last set to port 1 before the lock sequence
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h20, 32'h0);
    #1;
    checkOutput("solo1_gnt", 32'({gnt0, gnt1}), 32'h1);
    @(posedge clk); #1;
    checkOutput("solo1_rvalid", 32'({rvalid0, rvalid1}), 32'h1);
    checkOutput("solo1_rdata1", rdata1, 32'h0);

    // Lock on port 0: port 0 wins 8 times, then port 1 once, then port 0 again
    @(negedge clk);
    applyStimulus(1, 0, 0, 1, 32'h10, 32'h0, 1, 0, 0, 0, 32'h20, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput($sformatf("lock_gnt_%0d", i), 32'({gnt0, gnt1}), (i == 8) ? 32'h1 : 32'h2);
      @(negedge clk);
    end

    // Port 1 word write at 0x1FFFE is out of range and is rejected
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h1FFFE, 32'h12345678);
    #1;
    checkOutput("oor_gnt",    32'({gnt0, gnt1}), 32'h1);
    checkOutput("oor_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    checkOutput("oor_resp", 32'({rvalid1, rerr1}), 32'h3);
    checkOutput("oor_rdata1", rdata1, 32'h0);
    checkOutput("oor_untouched", 32'(mem[32'h1FFFE]), 32'h0);

    // Byte write to the last byte of memory succeeds
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 32'h1FFFF, 32'h00000077);
    #1;
    checkOutput("edge_bus", 32'({mem_we, mem_byteop}), 32'h3);
    @(posedge clk); #1;
    checkOutput("edge_resp", 32'({rvalid1, rerr1}), 32'h2);
    checkOutput("edge_mem", 32'(mem[32'h1FFFF]), 32'h77);

    // The highest legal word read
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 32'h1FFFC, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("topword_resp", 32'({rvalid0, rerr0}), 32'h2);
    checkOutput("topword_rdata0", rdata0, 32'h00000077);

    // Byte write of 0xA5 to 0x203 on port 1, then a word read of 0x200 on port 0
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 32'h203, 32'h000000A5);
    #1;
    checkOutput("bw_bus", 32'({mem_we, mem_byteop}), 32'h3);
    checkOutput("bw_addr", mem_addr, 32'h203);
    checkOutput("bw_wdata", mem_wdata, 32'h000000A5);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 32'h200, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("wr_bus", 32'({gnt0, mem_we, mem_byteop}), 32'h4);
    @(posedge clk); #1;
    checkOutput("wr_rdata0", rdata0, 32'h000000A5);

    // Reset in the middle of a granted port 0 write
    @(negedge clk);
    applyIdle();
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 32'h300, 32'h11223344, 0, 0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("mid_pre", 32'({gnt0, mem_we}), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_drop", 32'({gnt0, gnt1, mem_we}), 32'h0);
    @(posedge clk); #1;
    checkOutput("mid_rvalid", 32'({rvalid0, rvalid1}), 32'h0);
    @(negedge clk);
    applyIdle();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 32'h100, 32'h0, 1, 0, 0, 0, 32'h20, 32'h0);
    #1;
    checkOutput("exit_rvalid", 32'({rvalid0, rvalid1}), 32'h0);
    checkOutput("exit_gnt", 32'({gnt0, gnt1}), 32'h2);
    checkOutput("mid_mem", memWord(32'h300), 32'h0);
    @(posedge clk); #1;
    checkOutput("exit_rdata0", rdata0, 32'hDEADBEEF);
    @(negedge clk);
    applyIdle();
    @(posedge clk); #1;
    checkOutput("idle_rvalid", 32'({rvalid0, rvalid1}), 32'h0);
    checkOutput("idle_hold", rdata0, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
